// File: rtl/battle_disp_pkg.sv
// Shared types and register map for the battle display.
// Used by the SPI command controller and the display register file.
package battle_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        SKIP = 2'd2
    } disp_state_e;

    localparam logic [3:0] HDR_MAGIC_DEF = 4'hA;

    localparam int P1_HP     = 0;
    localparam int P2_HP     = 1;
    localparam int P1_SPRITE = 2;
    localparam int P2_SPRITE = 3;
    localparam int CURSOR    = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with a configurable reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI two-byte command receiver issuing display register writes.
// SPI_VBLANK_COMMIT_EN defers each write to the next vsync falling edge.
module spi_cmd_ctrl
    import battle_disp_pkg::*;
#(
    parameter int         NREG      = 16,
    parameter int         TIMEOUT   = 4096,
    parameter logic [3:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sck,
    input  logic                    mosi,
    input  logic                    vsync,
    output logic                    wr_en,
    output logic [$clog2(NREG)-1:0] wr_addr,
    output logic [7:0]              wr_data,
    output logic                    busy,
    output logic                    frame_err,
    output logic                    overrun
);

    localparam int AW = $clog2(NREG);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_DATA = DATA;
    localparam logic [1:0] S_SKIP = SKIP;

    logic          sck_s;
    logic          mosi_s;
    logic          sck_prev_q;
    logic          sck_rise_q;
    logic          sck_edge_q;
    logic          mosi_q;
    logic [6:0]    shift_q, shift_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ferr_q, ferr_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;

    logic          byte_done;
    logic [7:0]    byte_w;
    logic [31:0]   idx_w;
    logic          hdr_ok;
    logic          busy_w;
    logic          tmo_hit;
    logic          pkt_done;

    sync2 #(.RST_VAL(1'b0)) u_sync_sck (
        .clk   (clk),
        .reset (reset),
        .d_i   (sck),
        .q_o   (sck_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .reset (reset),
        .d_i   (mosi),
        .q_o   (mosi_s)
    );

    // Edge flags are registered so mosi_q stays aligned with sck_rise_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_prev_q <= 1'b0;
            sck_rise_q <= 1'b0;
            sck_edge_q <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            sck_prev_q <= sck_s;
            sck_rise_q <= sck_s & ~sck_prev_q;
            sck_edge_q <= sck_s ^ sck_prev_q;
            mosi_q     <= mosi_s;
        end
    end

    assign byte_w    = {shift_q, mosi_q};
    assign byte_done = sck_rise_q && (cnt_q == 3'd7);
    assign idx_w     = {28'd0, byte_w[3:0]};
    assign hdr_ok    = (byte_w[7:4] == HDR_MAGIC) && (idx_w < 32'(NREG));
    assign busy_w    = (state_q != S_IDLE) || (cnt_q != 3'd0);
    assign tmo_hit   = busy_w && !sck_edge_q && (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        addr_d   = addr_q;
        ferr_d   = 1'b0;
        pkt_done = 1'b0;
        tmo_d    = '0;
        if (!sck_edge_q && busy_w) begin
            tmo_d = tmo_q + TW'(1);
        end
        if (sck_rise_q) begin
            shift_d = byte_w[6:0];
            cnt_d   = cnt_q + 3'd1;
        end
        if (byte_done) begin
            unique case (state_q)
                S_IDLE: begin
                    if (hdr_ok) begin
                        addr_d  = idx_w[AW-1:0];
                        state_d = S_DATA;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_SKIP;
                    end
                end
                S_DATA: begin
                    pkt_done = 1'b1;
                    state_d  = S_IDLE;
                end
                S_SKIP:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        if (tmo_hit) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
            ferr_d  = 1'b1;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            shift_q <= 7'd0;
            addr_q  <= '0;
            tmo_q   <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            tmo_q   <= tmo_d;
            ferr_q  <= ferr_d;
        end
    end

`ifdef SPI_VBLANK_COMMIT_EN
    logic          vsync_s;
    logic          vs_prev_q;
    logic          vs_fall_q;
    logic          pend_v_q, pend_v_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [7:0]    pend_data_q, pend_data_d;
    logic          ovr_q, ovr_d;
    logic          commit;

    sync2 #(.RST_VAL(1'b1)) u_sync_vsync (
        .clk   (clk),
        .reset (reset),
        .d_i   (vsync),
        .q_o   (vsync_s)
    );

    assign commit = vs_fall_q && pend_v_q;

    // A packet landing on the commit cycle refills the slot just drained.
    always_comb begin
        wr_en_d     = commit;
        wr_addr_d   = commit ? pend_addr_q : wr_addr_q;
        wr_data_d   = commit ? pend_data_q : wr_data_q;
        pend_v_d    = pend_v_q && !commit;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        ovr_d       = pkt_done && pend_v_q && !commit;
        if (pkt_done) begin
            pend_v_d    = 1'b1;
            pend_addr_d = addr_q;
            pend_data_d = byte_w;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_prev_q   <= 1'b1;
            vs_fall_q   <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= 8'd0;
            ovr_q       <= 1'b0;
        end else begin
            vs_prev_q   <= vsync_s;
            vs_fall_q   <= vs_prev_q & ~vsync_s;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            ovr_q       <= ovr_d;
        end
    end

    assign overrun = ovr_q;
`else
    logic unused_vsync;

    assign unused_vsync = vsync;

    always_comb begin
        wr_en_d   = pkt_done;
        wr_addr_d = pkt_done ? addr_q : wr_addr_q;
        wr_data_d = pkt_done ? byte_w : wr_data_q;
    end

    assign overrun = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'd0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_w;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Randomized bench for spi_cmd_ctrl against a packet-level reference model.
// Define SPI_VBLANK_COMMIT_EN to exercise deferred commit.
module tb_spi_cmd_ctrl;

    localparam int NREG = 16;
    localparam int TO   = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       vsync = 1'b1;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_rise = 0;
    int vs_cyc = 0;
    int ferr_n = 0;
    int ovr_n = 0;
    logic [11:0] wq[$];
    int wcyc[$];

    spi_cmd_ctrl #(.NREG(NREG), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .mosi      (mosi),
        .vsync     (vsync),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wq.push_back({wr_addr, wr_data});
            wcyc.push_back(cyc);
        end
        if (frame_err === 1'b1) ferr_n = ferr_n + 1;
        if (overrun === 1'b1) ovr_n = ovr_n + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq.delete();
        wcyc.delete();
        ferr_n = 0;
        ovr_n = 0;
    endtask

    task automatic send_bit(input logic b, input logic vs_low);
        mosi = b;
        tick(4);
        sck = 1'b1;
        if (vs_low) vsync = 1'b0;
        last_rise = cyc;
        tick(4);
        sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic vs_last);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], vs_last && (i == 0));
        end
    endtask

    task automatic fire_vblank();
`ifdef SPI_VBLANK_COMMIT_EN
        tick(4);
        vsync = 1'b0;
        vs_cyc = cyc;
        tick(8);
        vsync = 1'b1;
        tick(8);
`else
        tick(1);
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        n_cmp++;
        if (wr_en !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL reset_strobes: got wr_en=%b frame_err=%b overrun=%b want 0 0 0",
                     wr_en, frame_err, overrun);
        end
        n_cmp++;
        if (wr_addr !== 4'd0 || wr_data !== 8'd0) begin
            n_err++;
            $display("FAIL reset_wr: got addr=%0d data=%h want 0 00", wr_addr, wr_data);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        reset = 1'b0;
        tick(4);
    endtask

    task automatic test_basic_write();
        int exp_cyc;
        clear_mon();
        send_byte(8'hA2, 1'b0);
        send_byte(8'h5C, 1'b0);
        exp_cyc = last_rise + 4;
        tick(8);
        fire_vblank();
`ifdef SPI_VBLANK_COMMIT_EN
        exp_cyc = vs_cyc + 4;
`endif
        tick(4);
        n_cmp++;
        if (wq.size() != 1) begin
            n_err++;
            $display("FAIL basic_count: got %0d writes want 1", wq.size());
        end else begin
            n_cmp++;
            if (wq[0] !== {4'd2, 8'h5C}) begin
                n_err++;
                $display("FAIL basic_data: got %h want 25c", wq[0]);
            end
            n_cmp++;
            if (wcyc[0] != exp_cyc) begin
                n_err++;
                $display("FAIL basic_latency: got cycle %0d want %0d", wcyc[0], exp_cyc);
            end
        end
        n_cmp++;
        if (ferr_n != 0) begin
            n_err++;
            $display("FAIL basic_ferr: got %0d pulses want 0", ferr_n);
        end
    endtask

    task automatic test_bad_header();
        clear_mon();
        send_byte(8'h33, 1'b0);
        tick(6);
        n_cmp++;
        if (ferr_n != 1) begin
            n_err++;
            $display("FAIL badhdr_ferr: got %0d pulses want 1", ferr_n);
        end
        send_byte(8'h77, 1'b0);
        send_byte(8'hA0, 1'b0);
        send_byte(8'h01, 1'b0);
        tick(6);
        fire_vblank();
        tick(4);
        n_cmp++;
        if (wq.size() != 1 || ferr_n != 1) begin
            n_err++;
            $display("FAIL badhdr_count: got %0d writes %0d errs want 1 1", wq.size(), ferr_n);
        end else begin
            n_cmp++;
            if (wq[0] !== {4'd0, 8'h01}) begin
                n_err++;
                $display("FAIL badhdr_data: got %h want 001", wq[0]);
            end
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        tick(10);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_busy_partial: got %b want 1", busy);
        end
        tick(TO + 20);
        n_cmp++;
        if (ferr_n != 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_expire: got errs=%0d busy=%b want 1 0", ferr_n, busy);
        end
        send_byte(8'hA1, 1'b0);
        send_byte(8'hFF, 1'b0);
        tick(6);
        fire_vblank();
        tick(4);
        n_cmp++;
        if (wq.size() != 1 || ferr_n != 1) begin
            n_err++;
            $display("FAIL tmo_after: got %0d writes %0d errs want 1 1", wq.size(), ferr_n);
        end else begin
            n_cmp++;
            if (wq[0] !== {4'd1, 8'hFF}) begin
                n_err++;
                $display("FAIL tmo_after_data: got %h want 1ff", wq[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send_byte(8'hA4, 1'b0);
        tick(6);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_busy_pre: got %b want 1", busy);
        end
        reset = 1'b1;
        tick(2);
        n_cmp++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 8'd0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got busy=%b wr_en=%b addr=%0d data=%h want 0 0 0 00",
                     busy, wr_en, wr_addr, wr_data);
        end
        reset = 1'b0;
        tick(4);
        clear_mon();
        send_byte(8'h10, 1'b0);
        tick(6);
        n_cmp++;
        if (ferr_n != 1) begin
            n_err++;
            $display("FAIL rstmid_hdr: got %0d errs want 1", ferr_n);
        end
        send_byte(8'h00, 1'b0);
        tick(6);
        fire_vblank();
        n_cmp++;
        if (wq.size() != 0) begin
            n_err++;
            $display("FAIL rstmid_nowrite: got %0d writes want 0", wq.size());
        end
    endtask

    task automatic test_random();
        logic [11:0] exp_q[$];
        int exp_err;
        logic [3:0] nib;
        logic [3:0] ad;
        logic [7:0] dat;
        clear_mon();
        exp_err = 0;
        for (int p = 0; p < 24; p++) begin
            ad  = 4'($urandom_range(0, NREG - 1));
            dat = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                send_byte({4'hA, ad}, 1'b0);
                exp_q.push_back({ad, dat});
            end else begin
                nib = 4'($urandom_range(0, 15));
                if (nib == 4'hA) nib = 4'h5;
                send_byte({nib, ad}, 1'b0);
                exp_err++;
            end
            send_byte(dat, 1'b0);
            tick(6);
            fire_vblank();
        end
        tick(4);
        n_cmp++;
        if (wq.size() != exp_q.size() || ferr_n != exp_err) begin
            n_err++;
            $display("FAIL rand_counts: got %0d writes %0d errs want %0d %0d",
                     wq.size(), ferr_n, exp_q.size(), exp_err);
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (wq[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL rand_write[%0d]: got %h want %h", i, wq[i], exp_q[i]);
                end
            end
        end
    endtask

`ifdef SPI_VBLANK_COMMIT_EN
    task automatic test_overrun();
        clear_mon();
        send_byte(8'hA3, 1'b0);
        send_byte(8'h11, 1'b0);
        tick(6);
        send_byte(8'hA3, 1'b0);
        send_byte(8'h22, 1'b0);
        tick(6);
        n_cmp++;
        if (ovr_n != 1 || wq.size() != 0) begin
            n_err++;
            $display("FAIL ovr_pending: got ovr=%0d writes=%0d want 1 0", ovr_n, wq.size());
        end
        fire_vblank();
        n_cmp++;
        if (wq.size() != 1) begin
            n_err++;
            $display("FAIL ovr_commit_count: got %0d writes want 1", wq.size());
        end else begin
            n_cmp++;
            if (wq[0] !== {4'd3, 8'h22}) begin
                n_err++;
                $display("FAIL ovr_commit_data: got %h want 322", wq[0]);
            end
        end
    endtask

    task automatic test_same_cycle();
        int c;
        clear_mon();
        send_byte(8'hA1, 1'b0);
        send_byte(8'h55, 1'b0);
        tick(6);
        send_byte(8'hA2, 1'b0);
        send_byte(8'h66, 1'b1);
        c = last_rise;
        tick(8);
        vsync = 1'b1;
        tick(8);
        n_cmp++;
        if (wq.size() != 1 || ovr_n != 0) begin
            n_err++;
            $display("FAIL same_first: got %0d writes ovr=%0d want 1 0", wq.size(), ovr_n);
        end else begin
            n_cmp++;
            if (wq[0] !== {4'd1, 8'h55} || wcyc[0] != c + 4) begin
                n_err++;
                $display("FAIL same_first_data: got %h at %0d want 155 at %0d",
                         wq[0], wcyc[0], c + 4);
            end
        end
        fire_vblank();
        n_cmp++;
        if (wq.size() != 2) begin
            n_err++;
            $display("FAIL same_second_count: got %0d writes want 2", wq.size());
        end else begin
            n_cmp++;
            if (wq[1] !== {4'd2, 8'h66}) begin
                n_err++;
                $display("FAIL same_second_data: got %h want 266", wq[1]);
            end
        end
    endtask
`else
    task automatic test_no_overrun();
        clear_mon();
        send_byte(8'hA3, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'hA3, 1'b0);
        send_byte(8'h22, 1'b0);
        tick(6);
        vsync = 1'b0;
        tick(8);
        vsync = 1'b1;
        tick(8);
        n_cmp++;
        if (ovr_n != 0 || wq.size() != 2) begin
            n_err++;
            $display("FAIL immediate_two: got ovr=%0d writes=%0d want 0 2", ovr_n, wq.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_write();
        test_bad_header();
        test_timeout();
        test_reset_mid();
        test_random();
`ifdef SPI_VBLANK_COMMIT_EN
        test_overrun();
        test_same_cycle();
`else
        test_no_overrun();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
